// File: rtl/cycle_timing_gen.sv
// i4004 instruction-cycle timing generator: two-phase clock, eight
// subcycle strobes and single/double-cycle scheduling with run/halt.
module cycle_timing_gen #(
  parameter int CLK_DIV = 17
) (
  input  logic sysclk,
  input  logic poc,
  input  logic run,
  input  logic dc_next,
  output logic clk1,
  output logic clk2,
  output logic a12,
  output logic a22,
  output logic a32,
  output logic m12,
  output logic m22,
  output logic x12,
  output logic x22,
  output logic x32,
  output logic sync,
  output logic sc,
  output logic dc,
  output logic cycle_start,
  output logic idle
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [1:0] slot, slot_nx;
  logic [2:0] sub, sub_nx;
  logic sc_nx;
  logic boundary;
  logic active_nx;
  logic [7:0] stb, stb_nx;
  logic clk1_nx, clk2_nx, sync_nx, cs_nx;

  assign boundary = (state == RUN) && (sub == 3'd7)
                  && (slot == 2'd3) && (div == DIV_MAX);

  always_comb begin
    state_nx = state;
    div_nx   = div;
    slot_nx  = slot;
    sub_nx   = sub;
    sc_nx    = sc;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_nx = RUN;
          div_nx   = '0;
          slot_nx  = 2'd0;
          sub_nx   = 3'd0;
        end
      end
      RUN: begin
        if (boundary) begin
          // second word of a two-word instruction is never extended
          sc_nx   = sc ? ~dc_next : 1'b1;
          div_nx  = '0;
          slot_nx = 2'd0;
          sub_nx  = 3'd0;
          if (!run) state_nx = IDLE;
        end else if (div == DIV_MAX) begin
          div_nx  = '0;
          slot_nx = slot + 2'd1;
          if (slot == 2'd3) sub_nx = sub + 3'd1;
        end else begin
          div_nx = div + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // outputs are decoded from next-state so they land in flops
  always_comb begin
    active_nx = (state_nx == RUN);
    clk1_nx   = active_nx && (slot_nx == 2'd0);
    clk2_nx   = active_nx && (slot_nx == 2'd2);
    stb_nx    = active_nx ? (8'd1 << sub_nx) : 8'd0;
    sync_nx   = active_nx && (sub_nx == 3'd7);
    cs_nx     = active_nx && (sub_nx == 3'd0)
              && (slot_nx == 2'd0) && (div_nx == '0);
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state       <= IDLE;
      div         <= '0;
      slot        <= 2'd0;
      sub         <= 3'd0;
      sc          <= 1'b1;
      dc          <= 1'b0;
      clk1        <= 1'b0;
      clk2        <= 1'b0;
      stb         <= 8'd0;
      sync        <= 1'b0;
      cycle_start <= 1'b0;
      idle        <= 1'b1;
    end else begin
      state       <= state_nx;
      div         <= div_nx;
      slot        <= slot_nx;
      sub         <= sub_nx;
      sc          <= sc_nx;
      dc          <= ~sc_nx;
      clk1        <= clk1_nx;
      clk2        <= clk2_nx;
      stb         <= stb_nx;
      sync        <= sync_nx;
      cycle_start <= cs_nx;
      idle        <= ~active_nx;
    end
  end

  assign a12 = stb[0];
  assign a22 = stb[1];
  assign a32 = stb[2];
  assign m12 = stb[3];
  assign m22 = stb[4];
  assign x12 = stb[5];
  assign x22 = stb[6];
  assign x32 = stb[7];

endmodule

// File: tb/tb_cycle_timing_gen.sv
// Directed bench for cycle_timing_gen at CLK_DIV=2 and CLK_DIV=1.
module tb_cycle_timing_gen;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int failures = 0;

  logic poc2 = 1'b1, run2 = 1'b0, dcn2 = 1'b0;
  logic clk1_2, clk2_2, a12_2, a22_2, a32_2, m12_2, m22_2;
  logic x12_2, x22_2, x32_2, sync_2, sc2, dco2, cs_2, idle_2;

  logic poc1 = 1'b1, run1 = 1'b0, dcn1 = 1'b0;
  logic clk1_1, clk2_1, a12_1, a22_1, a32_1, m12_1, m22_1;
  logic x12_1, x22_1, x32_1, sync_1, sc1, dco1, cs_1, idle_1;

  cycle_timing_gen #(.CLK_DIV(2)) u2 (
    .sysclk(sysclk), .poc(poc2), .run(run2), .dc_next(dcn2),
    .clk1(clk1_2), .clk2(clk2_2),
    .a12(a12_2), .a22(a22_2), .a32(a32_2), .m12(m12_2),
    .m22(m22_2), .x12(x12_2), .x22(x22_2), .x32(x32_2),
    .sync(sync_2), .sc(sc2), .dc(dco2),
    .cycle_start(cs_2), .idle(idle_2)
  );

  cycle_timing_gen #(.CLK_DIV(1)) u1 (
    .sysclk(sysclk), .poc(poc1), .run(run1), .dc_next(dcn1),
    .clk1(clk1_1), .clk2(clk2_1),
    .a12(a12_1), .a22(a22_1), .a32(a32_1), .m12(m12_1),
    .m22(m22_1), .x12(x12_1), .x22(x22_1), .x32(x32_1),
    .sync(sync_1), .sc(sc1), .dc(dco1),
    .cycle_start(cs_1), .idle(idle_1)
  );

  logic [12:0] obs2, obs1;
  assign obs2 = {clk1_2, clk2_2, x32_2, x22_2, x12_2, m22_2,
                 m12_2, a32_2, a22_2, a12_2, sync_2, cs_2, idle_2};
  assign obs1 = {clk1_1, clk2_1, x32_1, x22_1, x12_1, m22_1,
                 m12_1, a32_1, a22_1, a12_1, sync_1, cs_1, idle_1};

  localparam logic [12:0] RST_V = 13'h0001;

  // expected {clk1,clk2,strobes[7:0],sync,cycle_start,idle}
  // i sysclk after the first A1 edge, running continuously
  function automatic logic [12:0] expv(int i, int d);
    int p, s, q;
    logic [7:0] st;
    p  = i % (32 * d);
    s  = p / (4 * d);
    q  = p % (4 * d);
    st = 8'd1 << s;
    return {q < d, (q >= 2 * d) && (q < 3 * d), st,
            s == 7, p == 0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic start2(input logic dn);
    poc2 = 1'b1;
    run2 = 1'b0;
    dcn2 = dn;
    tick();
    tick();
    poc2 = 1'b0;
    run2 = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    poc2 = 1'b1;
    run2 = 1'b1;
    tick();
    tick();
    checks++;
    if ({obs2, sc2, dco2} !== {RST_V, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals got=%h exp=%h",
               {obs2, sc2, dco2}, {RST_V, 1'b1, 1'b0});
    end
    poc2 = 1'b0;
    tick();
    checks++;
    if (obs2 !== expv(0, 2)) begin
      failures++;
      $display("FAIL start_edge got=%h exp=%h", obs2, expv(0, 2));
    end
    repeat (3) tick();
    checks++;
    if (clk2_2 !== 1'b0) begin
      failures++;
      $display("FAIL clk2_early got=%b exp=0", clk2_2);
    end
    tick();
    checks++;
    if (clk2_2 !== 1'b1) begin
      failures++;
      $display("FAIL clk2_rise got=%b exp=1", clk2_2);
    end
    repeat (4) tick();
    checks++;
    if ({a22_2, a12_2} !== 2'b10) begin
      failures++;
      $display("FAIL a22_rise got=%b exp=10", {a22_2, a12_2});
    end
  endtask

  task automatic test_freerun();
    start2(1'b0);
    for (int i = 0; i < 192; i++) begin
      if (i != 0) tick();
      checks++;
      if (obs2 !== expv(i, 2)) begin
        failures++;
        $display("FAIL freerun i=%0d got=%h exp=%h",
                 i, obs2, expv(i, 2));
      end
      if (i % 64 == 3) begin
        checks++;
        if ({sc2, dco2} !== 2'b10) begin
          failures++;
          $display("FAIL sc_single i=%0d got=%b exp=10",
                   i, {sc2, dco2});
        end
      end
    end
  endtask

  task automatic test_dc_sched();
    logic [4:0] seq;
    seq = 5'b10101;
    start2(1'b1);
    for (int i = 0; i < 320; i++) begin
      if (i != 0) tick();
      if (i % 64 == 5) begin
        checks++;
        if ({sc2, dco2} !== {seq[4 - i / 64], ~seq[4 - i / 64]}) begin
          failures++;
          $display("FAIL dc_sched cyc=%0d got=%b exp=%b", i / 64,
                   {sc2, dco2}, {seq[4 - i / 64], ~seq[4 - i / 64]});
        end
      end
    end
  endtask

  task automatic test_halt();
    start2(1'b0);
    for (int i = 1; i < 64; i++) begin
      tick();
      if (i == 26) run2 = 1'b0;
      if (i == 40 || i == 63) begin
        checks++;
        if (obs2 !== expv(i, 2)) begin
          failures++;
          $display("FAIL halt_finish i=%0d got=%h exp=%h",
                   i, obs2, expv(i, 2));
        end
      end
    end
    tick();
    checks++;
    if ({obs2, sc2} !== {RST_V, 1'b1}) begin
      failures++;
      $display("FAIL halt_idle got=%h exp=%h",
               {obs2, sc2}, {RST_V, 1'b1});
    end
    run2 = 1'b1;
    tick();
    checks++;
    if (obs2 !== expv(0, 2)) begin
      failures++;
      $display("FAIL restart got=%h exp=%h", obs2, expv(0, 2));
    end
  endtask

  task automatic test_async_reset();
    start2(1'b1);
    repeat (100) tick();
    checks++;
    if ({obs2, sc2} !== {expv(100, 2), 1'b0}) begin
      failures++;
      $display("FAIL pre_reset got=%h exp=%h",
               {obs2, sc2}, {expv(100, 2), 1'b0});
    end
    #3;
    poc2 = 1'b1;
    #1;
    checks++;
    if ({obs2, sc2, dco2} !== {RST_V, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h",
               {obs2, sc2, dco2}, {RST_V, 1'b1, 1'b0});
    end
  endtask

  task automatic test_div1();
    poc1 = 1'b1;
    tick();
    checks++;
    if (obs1 !== RST_V) begin
      failures++;
      $display("FAIL div1_reset got=%h exp=%h", obs1, RST_V);
    end
    poc1 = 1'b0;
    run1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++;
      if (obs1 !== expv(i, 1)) begin
        failures++;
        $display("FAIL div1 i=%0d got=%h exp=%h",
                 i, obs1, expv(i, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_dc_sched();
    test_halt();
    test_async_reset();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cycle_timing_gen.md
# cycle_timing_gen

Instruction-cycle timing generator and cycle scheduler for the i4004 core. Divides `sysclk` into the non-overlapping two-phase clock (`clk1`, `clk2`) and the eight subcycle strobes (A1..X3) that sequence the scratchpad, ALU and instruction decode. It also schedules single- and double-cycle instructions by driving `sc`/`dc`. It supports run/halt at instruction-cycle boundaries.

## Interface
Parameters:
- `CLK_DIV`, default 17: sysclk cycles per phase slot; must be ≥1. Subcycle = 4·CLK_DIV sysclk (68 ≈ 1.36 µs at 50 MHz).

Ports:
- `sysclk`  in  1  FPGA clock (50 MHz); the only clock.
- `poc`  in  1  Power-On Clear. Reset is asynchronous and active-high.
- `run`  in  1  Continue executing. Sampled at the instruction-cycle boundary.
- `dc_next`  in  1  From decode: current instruction is two-word. Sampled at the boundary.
- `clk1`, `clk2`  out  1 each  Two-phase clock. Never high together.
- `a12`, `a22`, `a32`, `m12`, `m22`, `x12`, `x22`, `x32`  out  1 each  One-hot subcycle strobes. Each is high for its whole subcycle.
- `sync`  out  1  High during X3, marking end of cycle.
- `sc`, `dc`  out  1 each  Single-cycle / double-cycle phase of the current instruction cycle. `dc` = ~`sc`.
- `cycle_start`  out  1  One-sysclk pulse on the first sysclk of A1.
- `idle`  out  1  Generator halted.

## Operation
- Counters:
  - `div` (0..CLK_DIV-1) counts sysclk within a slot.
  - `slot` (0..3) counts slots within a subcycle.
  - `sub` (0..7 = A1,A2,A3,M1,M2,X1,X2,X3) counts subcycles.
  - `div` wraps and advances `slot`; `slot` wraps and advances `sub`; `sub` wraps X3→A1.
- Slot meaning: slot0 `clk1`=1; slot1 both clocks low; slot2 `clk2`=1; slot3 both clocks low.
- States:
  - IDLE: all strobes and clocks 0, `idle`=1. On `run`=1, go to RUN at A1/slot0/div0 on the next edge.
  - RUN: counters free-run.
- Boundary: the last sysclk of X3 slot3 (`div`=CLK_DIV-1). At this edge:
  - If `run`=0: go to IDLE. `sc`/`dc` retain their updated values.
  - Otherwise wrap to A1.
- `sc` scheduling at the boundary edge (applies whether continuing or halting):
  - `sc`=1 and `dc_next`=1 → `sc`←0.
  - `sc`=0 → `sc`←1, forced; `dc_next` is ignored.
  - Otherwise `sc` stays 1.
  - The second cycle of a two-word instruction is never extended.
- All outputs are registered and glitch-free. Strobes and clocks change only on `sysclk` rising edges.
- `run` dropping mid-cycle has no effect until the boundary: the cycle always completes.

## Timing
- Reset (async, immediate, including mid-cycle):
  - `clk1`=`clk2`=0; all eight strobes 0; `sync`=0; `cycle_start`=0.
  - `sc`=1, `dc`=0, `idle`=1.
  - Counters 0, state IDLE.
- Start: first rising edge with `poc`=0 and `run`=1 leaves IDLE. Outputs after that edge: `clk1`=1, `a12`=1, `cycle_start`=1, `idle`=0.
- Within a subcycle, relative to subcycle start:
  - `clk1` high for sysclk 0..CLK_DIV-1.
  - `clk2` high for 2·CLK_DIV..3·CLK_DIV-1.
  - Gap of exactly CLK_DIV sysclk between `clk1` and `clk2`, and between `clk2` and the next `clk1`.
- Instruction cycle = 32·CLK_DIV sysclk. `sync` is high for the last 4·CLK_DIV sysclk of it.
- Back-to-back RUN: A1 of the next cycle begins on the edge immediately after X3 ends, with no dead sysclk.
- Restart from IDLE: one IDLE sysclk minimum between X3 end and the next A1.
- `sc` changes only on the boundary edge, so it is stable for an entire cycle.
- CLK_DIV=1: `div` is constant 0; each slot is one sysclk.

## Test plan
- Reset/start (CLK_DIV=2), `poc` pulse then `run`=1:
  - All outputs at reset values while `poc`=1.
  - First edge after release gives `clk1`=1, `a12`=1, `cycle_start`=1.
  - `clk2` rises 4 sysclk later.
  - `a22` rises 8 sysclk after `a12`.
- Free-run, 3 cycles (CLK_DIV=2):
  - Strobes one-hot in order A1..X3, each 8 sysclk.
  - `sync` high for 8 sysclk per 64.
  - `clk1`&`clk2` never both 1.
  - `cycle_start` pulses every 64 sysclk.
- DC scheduling, `dc_next`=1 held continuously: `sc` sequence across cycles is 1,0,1,0,1.
- DC scheduling, `dc_next`=0: `sc` stays 1.
- Halt: drop `run` during M1.
  - Cycle completes through X3, then `idle`=1 and all strobes 0.
  - Re-assert `run`: `a12` and `cycle_start` follow after one idle sysclk.
- Async reset in M2 with `clk2` high: all outputs return to reset values without waiting for a `sysclk` edge.
- CLK_DIV=1:
  - Subcycle = 4 sysclk; cycle = 32 sysclk.
  - `clk1` and `clk2` each high for 1 sysclk, separated by 1 low sysclk.
